mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one synchronous RAM.
// Data port has priority, bounded by a starvation counter that forces an instruction grant.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned MEM_DEPTH    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [31:0]   DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

  state_t        state, state_nxt;
  logic          gnt_i;
  logic          oor;
  logic [CW-1:0] starve;
  logic          pick_i;

  always_comb begin
    state_nxt = state;
    pick_i    = if_req && (!d_req || (starve == LIMIT));
    case (state)
      IDLE:     if (if_req || d_req) state_nxt = ISSUE;
      ISSUE:    state_nxt = COMPLETE;
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_en = (state == ISSUE) && !oor;
    if_ack = (state == COMPLETE) && gnt_i;
    d_ack  = (state == COMPLETE) && !gnt_i;
    if_err = if_ack && oor;
    d_err  = d_ack && oor;
    busy   = (state != IDLE);
  end

  // ram_addr/ram_rw/ram_wdata double as the latched request, so they hold outside ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_i     <= 1'b0;
      oor       <= 1'b0;
      starve    <= '0;
      ram_rw    <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (!if_req || pick_i) begin
            starve <= '0;
          end else if (d_req && (starve != LIMIT)) begin
            starve <= starve + 1'b1;
          end
          if (if_req || d_req) begin
            gnt_i <= pick_i;
            if (pick_i) begin
              ram_addr <= if_addr;
              ram_rw   <= 1'b1;
              oor      <= (if_addr >= DEPTH);
            end else begin
              ram_addr  <= d_addr;
              ram_rw    <= d_rw;
              ram_wdata <= d_wdata;
              oor       <= (d_addr >= DEPTH);
            end
          end
        end
        ISSUE: begin
          // rejected accesses present zero read data alongside the error ack
          if (oor) begin
            if (gnt_i) if_rdata <= '0;
            else       d_rdata  <= '0;
          end
        end
        COMPLETE: begin
          if (!oor && ram_rw) begin
            if (gnt_i) if_rdata <= ram_rdata;
            else       d_rdata  <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions, a monitor
// checks port, error flag and read data whenever an ack appears.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack, if_err;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b1;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        ram_en, ram_rw;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        busy;

  mem_arbiter #(.STARVE_LIMIT(3), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_err(d_err),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_rw) ram_rdata <= mem[ram_addr[7:0]];
      else        mem[ram_addr[7:0]] <= ram_wdata;
    end
  end

  typedef struct {
    bit          is_i;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_i, input bit err, input logic [31:0] rdata);
    exp_t e;
    e.is_i = is_i; e.err = err; e.rdata = rdata;
    q.push_back(e);
  endtask

  // Monitor: pop on each ack, check read data on the following cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_ack: if_ack=%b d_ack=%b with nothing expected", if_ack, d_ack);
        end else begin
          e = q.pop_front();
          chk("ack_if_port", {31'b0, if_ack}, {31'b0, e.is_i});
          chk("ack_d_port",  {31'b0, d_ack},  {31'b0, !e.is_i});
          chk("ack_err", {31'b0, (e.is_i ? if_err : d_err)}, {31'b0, e.err});
          @(negedge clk);
          chk(e.is_i ? "if_rdata" : "d_rdata", e.is_i ? if_rdata : d_rdata, e.rdata);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: %0d completions outstanding, expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; request held for one cycle only
  task automatic access(input bit is_i, input bit rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit err, input logic [31:0] rdata);
    push(is_i, err, rdata);
    if (is_i) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata;
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    if_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata; d_rw = ~rw;
    chk("issue_ram_en", {31'b0, ram_en}, {31'b0, !err});
    chk("issue_busy", {31'b0, busy}, 32'd1);
    if (!err) begin
      chk("issue_ram_addr", ram_addr, addr);
      chk("issue_ram_rw", {31'b0, ram_rw}, {31'b0, (is_i ? 1'b1 : rw)});
      if (!is_i && !rw) chk("issue_ram_wdata", ram_wdata, wdata);
    end
    @(negedge clk);
    chk("complete_ack", {31'b0, (is_i ? if_ack : d_ack)}, 32'd1);
    chk("complete_ram_en", {31'b0, ram_en}, 32'd0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'hA5A5A5A5;
    mem[5]   = 32'hDEADBEEF;
    mem[20]  = 32'h11112222;
    mem[21]  = 32'h33334444;
    mem[255] = 32'hCAFEF00D;

    #12;
    chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
    chk("rst_ram_rw", {31'b0, ram_rw}, 32'd1);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_acks", {28'b0, if_ack, if_err, d_ack, d_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single instruction read, one-cycle request
    access(1'b1, 1'b1, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    // write then read back; write leaves d_rdata unchanged
    access(1'b0, 1'b0, 32'd10, 32'h12345678, 1'b0, 32'h0);
    chk("mem10_written", mem[10], 32'h12345678);
    access(1'b0, 1'b1, 32'd10, 32'h0, 1'b0, 32'h12345678);
    // out-of-range write and read
    access(1'b0, 1'b0, 32'd256, 32'hBAD0BAD0, 1'b1, 32'h0);
    chk("mem0_untouched", mem[0], 32'hA5A5A5A5);
    chk("mem10_untouched", mem[10], 32'h12345678);
    access(1'b1, 1'b1, 32'd300, 32'd0, 1'b1, 32'h0);
    // highest valid address
    access(1'b0, 1'b1, 32'd255, 32'd0, 1'b0, 32'hCAFEF00D);

    // contention: D,D,D,I,D,D,D,I
    for (int unsigned r = 0; r < 2; r++) begin
      push(1'b0, 1'b0, 32'h11112222);
      push(1'b0, 1'b0, 32'h11112222);
      push(1'b0, 1'b0, 32'h11112222);
      push(1'b1, 1'b0, 32'h33334444);
    end
    if_addr = 32'd21; d_addr = 32'd20; d_rw = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    n = 0;
    for (int unsigned c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (if_ack || d_ack) n++;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("contention_ack_count", n, 32'd8);
    drain();

    // reset during ISSUE abandons the write
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'd30; d_wdata = 32'h77;
    @(negedge clk);
    chk("pre_reset_ram_en", {31'b0, ram_en}, 32'd1);
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk("reset_ram_en", {31'b0, ram_en}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_d_ack", {31'b0, d_ack}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
